// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory-access stage.
// Takes the ALU result as effective address and runs one data-memory
// transaction over a valid/ack bus. Handles byte-lane alignment, misalignment
// detection and a bus timeout. Returns an extended load result as a
// one-cycle response.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   req_valid/ready     request handshake from execute (ready = idle)
//   alu_result          effective address
//   rs2_data            store data
//   funct3              RV32I width/sign field
//   mem_write           1 = store, 0 = load
//   mem_req/we/addr/wdata/wstrb  registered bus request
//   mem_rdata, mem_ack  bus read data and completion
//   resp_valid          one-cycle response pulse
//   load_data           extended load result
//   misaligned          misaligned address (with resp_valid)
//   access_fault        timeout or illegal funct3 (with resp_valid)
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    input  logic [2:0]  funct3,
    input  logic        mem_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        resp_valid,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        access_fault
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        addr_lo_q;
    logic [2:0]        funct3_q;
    logic              we_q;

    logic              req_ready_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [31:0]       mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        mem_wstrb_q;
    logic              resp_valid_q;
    logic [31:0]       load_data_q;
    logic              misaligned_q;
    logic              access_fault_q;

    logic              illegal_c;
    logic              misal_c;
    logic [3:0]        wstrb_c;
    logic [31:0]       wdata_c;
    logic [7:0]        byte_c;
    logic [15:0]       half_c;
    logic [31:0]       ext_c;

    // Classify the incoming request and build lane-replicated store data.
    always_comb begin
        illegal_c = 1'b0;
        misal_c   = 1'b0;
        wstrb_c   = 4'b0000;
        wdata_c   = 32'h0;
        case (funct3)
            3'b000, 3'b001, 3'b010: illegal_c = 1'b0;
            3'b100, 3'b101:         illegal_c = mem_write;
            default:                illegal_c = 1'b1;
        endcase
        if (funct3[1:0] == 2'b01) begin
            misal_c = alu_result[0];
        end else if (funct3[1:0] == 2'b10) begin
            misal_c = (alu_result[1:0] != 2'b00);
        end
        if (mem_write) begin
            case (funct3[1:0])
                2'b00: begin
                    wstrb_c = 4'b0001 << alu_result[1:0];
                    wdata_c = {4{rs2_data[7:0]}};
                end
                2'b01: begin
                    wstrb_c = alu_result[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{rs2_data[15:0]}};
                end
                default: begin
                    wstrb_c = 4'b1111;
                    wdata_c = rs2_data;
                end
            endcase
        end
    end

    // Extract and extend the addressed byte/halfword from the bus read data.
    always_comb begin
        byte_c = mem_rdata[7:0];
        half_c = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ext_c  = mem_rdata;
        case (addr_lo_q)
            2'b00:   byte_c = mem_rdata[7:0];
            2'b01:   byte_c = mem_rdata[15:8];
            2'b10:   byte_c = mem_rdata[23:16];
            default: byte_c = mem_rdata[31:24];
        endcase
        case (funct3_q)
            3'b000:  ext_c = {{24{byte_c[7]}}, byte_c};
            3'b100:  ext_c = {24'h0, byte_c};
            3'b001:  ext_c = {{16{half_c[15]}}, half_c};
            3'b101:  ext_c = {16'h0, half_c};
            default: ext_c = mem_rdata;
        endcase
        if (we_q) begin
            ext_c = 32'h0;
        end
    end

    // Control FSM with registered bus and response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            addr_lo_q      <= 2'b00;
            funct3_q       <= 3'b000;
            we_q           <= 1'b0;
            req_ready_q    <= 1'b1;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 32'h0;
            mem_wdata_q    <= 32'h0;
            mem_wstrb_q    <= 4'b0000;
            resp_valid_q   <= 1'b0;
            load_data_q    <= 32'h0;
            misaligned_q   <= 1'b0;
            access_fault_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_lo_q   <= alu_result[1:0];
                        funct3_q    <= funct3;
                        we_q        <= mem_write;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        if (illegal_c) begin
                            access_fault_q <= 1'b1;
                            resp_valid_q   <= 1'b1;
                            state_q        <= S_RESP;
                        end else if (misal_c) begin
                            misaligned_q <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= mem_write;
                            mem_addr_q  <= {alu_result[31:2], 2'b00};
                            mem_wdata_q <= wdata_c;
                            mem_wstrb_q <= wstrb_c;
                            state_q     <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    // Ack beats an expiring counter in the same cycle.
                    if (mem_ack || (cnt_q == CNT_LAST)) begin
                        mem_req_q      <= 1'b0;
                        mem_we_q       <= 1'b0;
                        mem_addr_q     <= 32'h0;
                        mem_wdata_q    <= 32'h0;
                        mem_wstrb_q    <= 4'b0000;
                        cnt_q          <= '0;
                        resp_valid_q   <= 1'b1;
                        load_data_q    <= mem_ack ? ext_c : 32'h0;
                        access_fault_q <= !mem_ack;
                        state_q        <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    resp_valid_q   <= 1'b0;
                    load_data_q    <= 32'h0;
                    misaligned_q   <= 1'b0;
                    access_fault_q <= 1'b0;
                    req_ready_q    <= 1'b1;
                    state_q        <= S_IDLE;
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wstrb    = mem_wstrb_q;
    assign resp_valid   = resp_valid_q;
    assign load_data    = load_data_q;
    assign misaligned   = misaligned_q;
    assign access_fault = access_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with TIMEOUT_CYCLES = 4.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] alu_result = 32'h0;
    logic [31:0] rs2_data = 32'h0;
    logic [2:0]  funct3 = 3'b000;
    logic        mem_write = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        misaligned;
    logic        access_fault;

    int vectors = 0;
    int miscompares = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .alu_result(alu_result), .rs2_data(rs2_data),
        .funct3(funct3), .mem_write(mem_write),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .resp_valid(resp_valid), .load_data(load_data),
        .misaligned(misaligned), .access_fault(access_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge; returns in cycle N+1.
    task automatic issue(input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f3, input logic we);
        alu_result = a;
        rs2_data   = d;
        funct3     = f3;
        mem_write  = we;
        req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({req_ready, mem_req, mem_we, resp_valid, misaligned, access_fault} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 100000",
                     {req_ready, mem_req, mem_we, resp_valid, misaligned, access_fault});
        end
        vectors++;
        if ({mem_addr, mem_wdata, load_data, mem_wstrb} !== 100'h0) begin
            miscompares++;
            $display("FAIL reset_data: got addr=%h wdata=%h ld=%h strb=%b expected all zero",
                     mem_addr, mem_wdata, load_data, mem_wstrb);
        end
    endtask

    task automatic test_store_word();
        issue(32'h0000_1004, 32'hDEAD_BEEF, 3'b010, 1'b1);
        vectors++;
        if ({mem_req, mem_we, req_ready, mem_wstrb, mem_addr, mem_wdata} !==
            {3'b110, 4'b1111, 32'h0000_1004, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL sw_bus: got req=%b we=%b rdy=%b strb=%b addr=%h wdata=%h expected 1 1 0 1111 00001004 deadbeef",
                     mem_req, mem_we, req_ready, mem_wstrb, mem_addr, mem_wdata);
        end
        tick();
        vectors++;
        if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 32'h0000_1004, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL sw_hold: got req=%b addr=%h wdata=%h expected 1 00001004 deadbeef",
                     mem_req, mem_addr, mem_wdata);
        end
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        vectors++;
        if ({resp_valid, mem_req, misaligned, access_fault, load_data} !== {4'b1000, 32'h0}) begin
            miscompares++;
            $display("FAIL sw_resp: got rv=%b req=%b mis=%b flt=%b ld=%h expected 1 0 0 0 00000000",
                     resp_valid, mem_req, misaligned, access_fault, load_data);
        end
        tick();
        vectors++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL sw_idle: got rv=%b rdy=%b expected 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_store_lanes();
        logic [31:0] a  [3] = '{32'h0000_2003, 32'h0000_2002, 32'h0000_2001};
        logic [31:0] d  [3] = '{32'h0000_00A5, 32'h0000_1234, 32'h0000_005A};
        logic [2:0]  f  [3] = '{3'b000, 3'b001, 3'b000};
        logic [31:0] ea [3] = '{32'h0000_2000, 32'h0000_2000, 32'h0000_2000};
        logic [31:0] ed [3] = '{32'hA5A5_A5A5, 32'h1234_1234, 32'h5A5A_5A5A};
        logic [3:0]  es [3] = '{4'b1000, 4'b1100, 4'b0010};
        for (int i = 0; i < 3; i++) begin
            issue(a[i], d[i], f[i], 1'b1);
            vectors++;
            if ({mem_req, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, ea[i], ed[i], es[i]}) begin
                miscompares++;
                $display("FAIL store_lane%0d: got req=%b addr=%h wdata=%h strb=%b expected 1 %h %h %b",
                         i, mem_req, mem_addr, mem_wdata, mem_wstrb, ea[i], ed[i], es[i]);
            end
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            vectors++;
            if ({resp_valid, load_data} !== {1'b1, 32'h0}) begin
                miscompares++;
                $display("FAIL store_resp%0d: got rv=%b ld=%h expected 1 00000000", i, resp_valid, load_data);
            end
            tick();
        end
    endtask

    task automatic test_loads();
        logic [31:0] a [7] = '{32'h0000_3000, 32'h0000_3001, 32'h0000_3002, 32'h0000_3000,
                               32'h0000_3004, 32'h0000_3003, 32'h0000_3003};
        logic [2:0]  f [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b100, 3'b000};
        logic [31:0] e [7] = '{32'hFFFF_FF81, 32'h0000_007F, 32'hFFFF_80F0, 32'h0000_7F81,
                               32'h80F0_7F81, 32'h0000_0080, 32'hFFFF_FF80};
        for (int i = 0; i < 7; i++) begin
            issue(a[i], 32'hFFFF_FFFF, f[i], 1'b0);
            vectors++;
            if ({mem_req, mem_we, mem_wstrb, mem_wdata, mem_addr} !==
                {2'b10, 4'b0000, 32'h0, a[i] & 32'hFFFF_FFFC}) begin
                miscompares++;
                $display("FAIL load_bus%0d: got req=%b we=%b strb=%b wdata=%h addr=%h",
                         i, mem_req, mem_we, mem_wstrb, mem_wdata, mem_addr);
            end
            mem_rdata = 32'h80F0_7F81;
            mem_ack   = 1'b1;
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 32'h1357_9BDF;
            vectors++;
            if ({resp_valid, access_fault, misaligned, load_data} !== {3'b100, e[i]}) begin
                miscompares++;
                $display("FAIL load_data%0d: got rv=%b flt=%b mis=%b ld=%h expected 1 0 0 %h",
                         i, resp_valid, access_fault, misaligned, load_data, e[i]);
            end
            tick();
        end
    endtask

    task automatic test_misaligned_illegal();
        logic [31:0] a  [6] = '{32'h0000_1002, 32'h0000_1001, 32'h0000_1003,
                                32'h0000_1002, 32'h0000_1000, 32'h0000_1000};
        logic [2:0]  f  [6] = '{3'b010, 3'b001, 3'b001, 3'b011, 3'b100, 3'b110};
        logic        w  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0]  ef [6] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
        for (int i = 0; i < 6; i++) begin
            issue(a[i], 32'hCAFE_BABE, f[i], w[i]);
            vectors++;
            if ({mem_req, resp_valid, misaligned, access_fault, load_data} !==
                {2'b01, ef[i], 32'h0}) begin
                miscompares++;
                $display("FAIL nobus%0d: got req=%b rv=%b mis=%b flt=%b ld=%h expected 0 1 %b %b 00000000",
                         i, mem_req, resp_valid, misaligned, access_fault, load_data, ef[i][1], ef[i][0]);
            end
            tick();
            vectors++;
            if ({resp_valid, misaligned, access_fault, req_ready, mem_req} !== 5'b00010) begin
                miscompares++;
                $display("FAIL nobus_after%0d: got rv=%b mis=%b flt=%b rdy=%b req=%b expected 0 0 0 1 0",
                         i, resp_valid, misaligned, access_fault, req_ready, mem_req);
            end
        end
    endtask

    task automatic test_timeout();
        int hi = 0;
        issue(32'h0000_4000, 32'h0, 3'b010, 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (!mem_req) break;
            hi++;
            tick();
        end
        vectors++;
        if (hi !== 4) begin
            miscompares++;
            $display("FAIL timeout_len: got %0d cycles of mem_req expected 4", hi);
        end
        vectors++;
        if ({resp_valid, access_fault, misaligned, load_data} !== {3'b110, 32'h0}) begin
            miscompares++;
            $display("FAIL timeout_resp: got rv=%b flt=%b mis=%b ld=%h expected 1 1 0 00000000",
                     resp_valid, access_fault, misaligned, load_data);
        end
        tick();
        mem_rdata = 32'hAAAA_5555;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
        vectors++;
        if ({resp_valid, req_ready, mem_req} !== 3'b010) begin
            miscompares++;
            $display("FAIL late_ack: got rv=%b rdy=%b req=%b expected 0 1 0", resp_valid, req_ready, mem_req);
        end
        issue(32'h0000_4008, 32'h0, 3'b010, 1'b0);
        mem_rdata = 32'h1234_5678;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
        vectors++;
        if ({resp_valid, access_fault, load_data} !== {2'b10, 32'h1234_5678}) begin
            miscompares++;
            $display("FAIL after_timeout: got rv=%b flt=%b ld=%h expected 1 0 12345678",
                     resp_valid, access_fault, load_data);
        end
        tick();
    endtask

    task automatic test_ack_at_expiry();
        issue(32'h0000_5000, 32'h0, 3'b010, 1'b0);
        tick();
        tick();
        tick();
        mem_rdata = 32'hCAFE_F00D;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
        vectors++;
        if ({resp_valid, access_fault, load_data} !== {2'b10, 32'hCAFE_F00D}) begin
            miscompares++;
            $display("FAIL ack_expiry: got rv=%b flt=%b ld=%h expected 1 0 cafef00d",
                     resp_valid, access_fault, load_data);
        end
        tick();
    endtask

    task automatic test_reset_mid_bus();
        int seen = 0;
        issue(32'h0000_6000, 32'h1111_2222, 3'b010, 1'b1);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({mem_req, req_ready, mem_wstrb} !== {2'b01, 4'b0000}) begin
            miscompares++;
            $display("FAIL reset_async: got req=%b rdy=%b strb=%b expected 0 1 0000",
                     mem_req, req_ready, mem_wstrb);
        end
        mem_ack = 1'b1;
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (resp_valid) seen++;
            tick();
        end
        mem_ack = 1'b0;
        vectors++;
        if ({seen, req_ready} !== {32'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_noresp: got %0d responses rdy=%b expected 0 1", seen, req_ready);
        end
        issue(32'h0000_6002, 32'h0, 3'b101, 1'b0);
        mem_rdata = 32'hBEEF_0000;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
        vectors++;
        if ({resp_valid, load_data} !== {1'b1, 32'h0000_BEEF}) begin
            miscompares++;
            $display("FAIL reset_recover: got rv=%b ld=%h expected 1 0000beef", resp_valid, load_data);
        end
        tick();
    endtask

    initial begin
        tick();
        tick();
        test_reset();
        reset_n = 1'b1;
        tick();
        test_store_word();
        test_store_lanes();
        test_loads();
        test_misaligned_illegal();
        test_timeout();
        test_ack_at_expiry();
        test_reset_mid_bus();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
